// File: rtl/i2c_master_bit.sv
// rtl/i2c_master_bit.sv - bit-level I2C master: one START/STOP/data/ACK/NACK symbol per go/finish handshake
// Define I2C_OPEN_DRAIN_EN for open-drain inout scl/sda; default build drives push-pull outputs.
module i2c_master_bit #(
  parameter int QUARTER_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [2:0] command,
  output logic       finish,
`ifdef I2C_OPEN_DRAIN_EN
  inout  wire        scl,
  inout  wire        sda
`else
  output logic       scl,
  output logic       sda
`endif
);

  localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      cmd_q;
  logic [1:0]      phase;
  logic [QW-1:0]   qcnt;
  logic            scl_q, sda_q;
  logic            scl_lvl, sda_lvl;
  logic            last_quarter;
  logic            noop;
  logic            accept;

  assign last_quarter = (qcnt == QW'(QUARTER_CYCLES - 1));
  assign noop         = (command[2:1] == 2'b00);
  // finish is still high for one clock after DONE is left, so a new go waits for it to fall
  assign accept       = go && !finish;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = noop ? DONE : RUN;
      RUN:     if (phase == 2'd3 && last_quarter) state_next = DONE;
      DONE:    if (!go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scl_lvl = scl_q;
    sda_lvl = sda_q;
    case (cmd_q)
      3'b010: begin
        scl_lvl = (phase == 2'd1) || (phase == 2'd2);
        sda_lvl = (phase < 2'd2);
      end
      3'b011: begin
        scl_lvl = (phase != 2'd0);
        sda_lvl = (phase >= 2'd2);
      end
      3'b100, 3'b101, 3'b110, 3'b111: begin
        scl_lvl = (phase == 2'd1) || (phase == 2'd2);
        sda_lvl = cmd_q[0];
      end
      default: begin
        scl_lvl = scl_q;
        sda_lvl = sda_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q  <= 3'b000;
      phase  <= 2'd0;
      qcnt   <= '0;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      finish <= 1'b0;
    end else begin
      finish <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q <= command;
            phase <= 2'd0;
            qcnt  <= '0;
          end
        end
        RUN: begin
          // lines are re-registered every clock but only change value on a phase boundary
          scl_q <= scl_lvl;
          sda_q <= sda_lvl;
          if (last_quarter) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
          end else begin
            qcnt  <= qcnt + QW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_OPEN_DRAIN_EN
  assign scl = scl_q ? 1'bz : 1'b0;
  assign sda = sda_q ? 1'bz : 1'b0;
`else
  assign scl = scl_q;
  assign sda = sda_q;
`endif

endmodule

// File: tb/tb_i2c_master_bit.sv
// tb/tb_i2c_master_bit.sv - scoreboard bench for i2c_master_bit
module tb_i2c_master_bit;
  localparam int Q = 5;

  logic       clock;
  logic       reset_n;
  logic       go;
  logic [2:0] command;
  logic       finish;
  wire        scl;
  wire        sda;

  i2c_master_bit #(.QUARTER_CYCLES(Q)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .command (command),
    .finish  (finish),
    .scl     (scl),
    .sda     (sda)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       noop;
    bit [3:0] scl_w;
    bit [3:0] sda_w;
    bit       scl_f;
    bit       sda_f;
    int       lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   lat, fall;
    bit   wave_bad, hold_bad;
    forever begin
      @(negedge clock);
      if (!(mon_en && go && !finish)) continue;
      if (q.size() == 0) begin
        check("unexpected_symbol", 1, 0);
        continue;
      end
      e = q.pop_front();
      lat = 0;
      wave_bad = 0;
      for (int c = 0; c <= 40; c++) begin
        @(negedge clock);
        if (finish) begin
          lat = c;
          break;
        end
        if (!e.noop && c >= 1 && c <= 4 * Q) begin
          if (scl !== e.scl_w[(c - 1) / Q] || sda !== e.sda_w[(c - 1) / Q]) wave_bad = 1;
        end
      end
      check("finish_latency", lat, e.lat);
      if (!e.noop) check("waveform", int'(wave_bad), 0);
      check("final_scl", int'(scl), int'(e.scl_f));
      check("final_sda", int'(sda), int'(e.sda_f));
      hold_bad = 0;
      for (int h = 0; h < 200 && go; h++) begin
        @(negedge clock);
        if (go && (!finish || scl !== e.scl_f || sda !== e.sda_f)) hold_bad = 1;
      end
      check("hold_done", int'(hold_bad), 0);
      fall = -1;
      for (int j = 0; j <= 10; j++) begin
        @(negedge clock);
        if (!finish) begin
          fall = j;
          break;
        end
      end
      check("finish_fall", fall, 1);
    end
  end

  task automatic issue(input logic [2:0] cmd, input bit [3:0] sw, input bit [3:0] dw,
                       input bit sf, input bit df, input int lat, input int hold,
                       input bit mid_change);
    exp_t e;
    e.noop  = (cmd[2:1] == 2'b00);
    e.scl_w = sw;
    e.sda_w = dw;
    e.scl_f = sf;
    e.sda_f = df;
    e.lat   = lat;
    q.push_back(e);
    command = cmd;
    go = 1'b1;
    if (mid_change) begin
      repeat (3) begin @(posedge clock); #2; end
      command = 3'b101;
    end
    for (int n = 0; n < 100 && !finish; n++) begin @(posedge clock); #2; end
    repeat (hold) begin @(posedge clock); #2; end
    go = 1'b0;
    for (int n = 0; n < 20 && finish; n++) begin @(posedge clock); #2; end
    @(posedge clock); #2;
  endtask

  initial begin
    reset_n = 1'b0;
    go = 1'b0;
    command = 3'b000;
    #10;
    check("reset_scl", int'(scl), 1);
    check("reset_sda", int'(sda), 1);
    check("reset_finish", int'(finish), 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #2;

    // data 0 interrupted by reset while scl is high in Q1
    command = 3'b100;
    go = 1'b1;
    repeat (8) begin @(posedge clock); #2; end
    check("midbit_sda_low", int'(sda), 0);
    check("midbit_scl_high", int'(scl), 1);
    reset_n = 1'b0;
    go = 1'b0;
    #1;
    check("async_reset_scl", int'(scl), 1);
    check("async_reset_sda", int'(sda), 1);
    check("async_reset_finish", int'(finish), 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (2) begin @(posedge clock); #2; end
    mon_en = 1;

    //     cmd     scl(Q3..Q0) sda(Q3..Q0) scl_f sda_f lat hold mid
    issue(3'b010, 4'b0110,   4'b0011,   1'b0, 1'b0, 21, 0, 1'b0);  // START
    issue(3'b100, 4'b0110,   4'b0000,   1'b0, 1'b0, 21, 0, 1'b1);  // data 0, command changed mid-bit
    issue(3'b101, 4'b0110,   4'b1111,   1'b0, 1'b1, 21, 0, 1'b0);  // data 1
    issue(3'b110, 4'b0110,   4'b0000,   1'b0, 1'b0, 21, 0, 1'b0);  // ACK
    issue(3'b111, 4'b0110,   4'b1111,   1'b0, 1'b1, 21, 6, 1'b0);  // NACK, go held in DONE
    issue(3'b000, 4'b0000,   4'b0000,   1'b0, 1'b1, 1,  0, 1'b0);  // no-op keeps lines
    issue(3'b011, 4'b1110,   4'b1100,   1'b1, 1'b1, 21, 0, 1'b0);  // STOP
    issue(3'b001, 4'b0000,   4'b0000,   1'b1, 1'b1, 1,  3, 1'b0);  // no-op after STOP

    repeat (5) begin @(posedge clock); #2; end
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
